// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the two-port memory arbiter.
//   arb_state_t  - FSM states (IDLE / WAIT / RESP)
//   arb_owner_t  - which port owns the outstanding transaction
//   mem_req_t    - memory command selected for the granted port
package mem_arb_pkg;

  localparam int DEF_MEM_LATENCY  = 2;
  localparam int DEF_STARVE_LIMIT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DS = 1'b1
  } arb_owner_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: grant selection between fetch and data ports plus the
// fetch starvation counter.
//   clk, reset        - clock, async active-high reset
//   grant_en          - arbiter may issue a grant this cycle
//   if_req, ds_req    - pending requests
//   grant_if/grant_ds - one-hot (or zero) grant, combinational
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic grant_en,
  input  logic if_req,
  input  logic ds_req,
  output logic grant_if,
  output logic grant_ds
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt;
  logic          at_limit;

  assign at_limit = (starve_cnt == CW'(STARVE_LIMIT));

  // Data side normally wins; fetch wins only once it has been passed over
  // STARVE_LIMIT times in a row.
  always_comb begin
    grant_ds = grant_en & ds_req & ~(if_req & at_limit);
    grant_if = grant_en & if_req & ~grant_ds;
  end

  // Counts data-side wins against a waiting fetch; any cycle without a fetch
  // request, or a fetch grant, starts the count over.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      starve_cnt <= '0;
    else if (!if_req || grant_if)
      starve_cnt <= '0;
    else if (grant_ds && !at_limit)
      starve_cnt <= starve_cnt + CW'(1);
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-outstanding arbiter sharing one fixed-latency memory
// between an instruction-fetch port and a load/store port.
//   clk, reset                          - clock, async active-high reset
//   if_req/if_addr/if_ready             - fetch request handshake
//   if_rvalid/if_rdata                  - fetch response (1-cycle pulse)
//   ds_req/ds_we/ds_addr/ds_wdata/ds_ready - load/store request handshake
//   ds_rvalid/ds_rdata                  - load data / store acknowledge
//   mem_en/mem_we/mem_addr/mem_wdata    - memory command, valid on grant only
//   mem_rdata                           - memory data, MEM_LATENCY after issue
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY  = DEF_MEM_LATENCY,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ds_req,
  input  logic        ds_we,
  input  logic [31:0] ds_addr,
  input  logic [31:0] ds_wdata,
  output logic        ds_ready,
  output logic        ds_rvalid,
  output logic [31:0] ds_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  arb_state_t state_q, state_d;
  arb_owner_t owner_q;
  logic [2:0]  lat_q;
  logic [31:0] rdata_q;
  logic        grant_en, grant_if, grant_ds, grant;
  logic        lat_done;
  mem_req_t    cmd;

  // Reset also gates the grant so every output reads 0 while it is held,
  // even with requests pending.
  assign grant_en = (state_q == IDLE) & ~reset;
  assign grant    = grant_if | grant_ds;
  assign lat_done = (lat_q == 3'(MEM_LATENCY - 1));

  mem_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .clk      (clk),
    .reset    (reset),
    .grant_en (grant_en),
    .if_req   (if_req),
    .ds_req   (ds_req),
    .grant_if (grant_if),
    .grant_ds (grant_ds)
  );

  // Memory command comes straight from the winner; zero when nothing granted.
  always_comb begin
    cmd = '0;
    if (grant_ds)
      cmd = '{we: ds_we, addr: ds_addr, wdata: ds_we ? ds_wdata : 32'h0};
    else if (grant_if)
      cmd = '{we: 1'b0, addr: if_addr, wdata: 32'h0};
  end

  always_comb begin
    state_d   = state_q;
    if_ready  = grant_if;
    ds_ready  = grant_ds;
    mem_en    = grant;
    mem_we    = cmd.we;
    mem_addr  = cmd.addr;
    mem_wdata = cmd.wdata;
    if_rvalid = 1'b0;
    ds_rvalid = 1'b0;
    unique case (state_q)
      IDLE: if (grant) state_d = WAIT;
      WAIT: if (lat_done) state_d = RESP;
      RESP: begin
        if_rvalid = (owner_q == OWN_IF);
        ds_rvalid = (owner_q == OWN_DS);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Both ports read the same capture register; only the rvalid tells which
  // port the data belongs to.
  assign if_rdata = rdata_q;
  assign ds_rdata = rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      lat_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q <= grant_ds ? OWN_DS : OWN_IF;
        lat_q   <= '0;
      end else if (state_q == WAIT) begin
        if (lat_done)
          rdata_q <= mem_rdata;
        else
          lat_q <= lat_q + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed + randomized bench with a timing/priority
// reference model, scoreboard queue and a negedge monitor.
module tb_mem_arbiter;

  localparam int LAT = 2;
  localparam int LIM = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready, if_rvalid;
  logic [31:0] if_rdata;
  logic        ds_req = 1'b0, ds_we = 1'b0;
  logic [31:0] ds_addr = '0, ds_wdata = '0;
  logic        ds_ready, ds_rvalid;
  logic [31:0] ds_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  // second instance, MEM_LATENCY = 1, fetch port only
  logic        if_req1 = 1'b0;
  logic [31:0] if_addr1 = '0;
  logic        if_ready1, if_rvalid1, ds_ready1, ds_rvalid1, mem_en1, mem_we1;
  logic [31:0] if_rdata1, ds_rdata1, mem_addr1, mem_wdata1;
  logic [31:0] mem_rdata1 = '0;

  mem_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(LIM)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ds_req(ds_req), .ds_we(ds_we), .ds_addr(ds_addr), .ds_wdata(ds_wdata),
    .ds_ready(ds_ready), .ds_rvalid(ds_rvalid), .ds_rdata(ds_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(LIM)) u_dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req1), .if_addr(if_addr1), .if_ready(if_ready1),
    .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .ds_req(1'b0), .ds_we(1'b0), .ds_addr(32'h0), .ds_wdata(32'h0),
    .ds_ready(ds_ready1), .ds_rvalid(ds_rvalid1), .ds_rdata(ds_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          is_ds;
    bit          is_st;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  bit          glog[$];          // 1 = data side won
  logic [31:0] mem_model [logic [31:0]];
  int          starve   = 0;
  int          next_ok  = 0;     // first cycle a new grant may happen
  int          resp_cyc = -1;
  logic [31:0] resp_data = '0;
  bit          acc_if = 0, acc_ds = 0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : (a ^ 32'hA5A5_0000);
  endfunction

  function automatic logic [31:0] outs_or();
    return mem_addr | mem_wdata | if_rdata | ds_rdata |
           {26'd0, if_ready, ds_ready, if_rvalid, ds_rvalid, mem_en, mem_we};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    bit   w_ds;
    if (reset) begin
      chk("reset_outputs", outs_or(), 32'h0);
      sbq.delete();
      starve   = 0;
      next_ok  = 0;
      resp_cyc = -1;
      acc_if   = 0;
      acc_ds   = 0;
    end else begin
      // response side
      if (if_rvalid || ds_rvalid) begin
        if (sbq.size() == 0) fail_now("unexpected_rvalid");
        else begin
          e = sbq.pop_front();
          chk("rvalid_cycle", 32'(cyc), 32'(e.due));
          chk("rvalid_owner", {30'd0, if_rvalid, ds_rvalid}, e.is_ds ? 32'd1 : 32'd2);
          if (!e.is_st) chk("rdata", e.is_ds ? ds_rdata : if_rdata, e.data);
        end
      end else if (sbq.size() > 0 && sbq[0].due < cyc) begin
        fail_now("missing_rvalid");
        void'(sbq.pop_front());
      end
      // request side
      acc_if = if_ready;
      acc_ds = ds_ready;
      if (cyc >= next_ok && (if_req || ds_req)) begin
        w_ds = ds_req && !(if_req && starve == LIM);
        chk("if_ready", 32'(if_ready), 32'(!w_ds));
        chk("ds_ready", 32'(ds_ready), 32'(w_ds));
        chk("mem_en", 32'(mem_en), 32'd1);
        chk("mem_we", 32'(mem_we), 32'(w_ds && ds_we));
        chk("mem_addr", mem_addr, w_ds ? ds_addr : if_addr);
        if (w_ds && ds_we) chk("mem_wdata", mem_wdata, ds_wdata);
        if (w_ds && if_req) starve = (starve < LIM) ? starve + 1 : LIM;
        else if (!w_ds) starve = 0;
        e.is_ds = w_ds;
        e.is_st = w_ds && ds_we;
        if (e.is_st) mem_model[ds_addr] = ds_wdata;
        e.data  = rd(w_ds ? ds_addr : if_addr);
        e.due   = cyc + LAT + 1;
        sbq.push_back(e);
        resp_cyc  = cyc + LAT;
        resp_data = e.data;
        next_ok   = cyc + LAT + 2;
        glog.push_back(w_ds);
      end else begin
        chk("no_grant", {28'd0, if_ready, ds_ready, mem_en, mem_we}, 32'h0);
      end
      if (!if_req) starve = 0;
    end
    // memory: valid data only in the cycle the arbiter should capture it
    mem_rdata = (cyc == resp_cyc) ? resp_data : $urandom();
  end

  // ---------------- latency-1 instance monitor ----------------
  bit          lat1_on = 0;
  int          g1_last = -1, g1_cnt = 0, r1_cyc = -1, r1_due = -1;
  logic [31:0] r1_data = '0;
  bit          acc_if1 = 0;

  always @(negedge clk) begin
    if (!reset && lat1_on) begin
      if (ds_rvalid1 || ds_ready1) fail_now("lat1_ds_activity");
      if (if_rvalid1) begin
        chk("lat1_rvalid_cycle", 32'(cyc), 32'(r1_due));
        chk("lat1_rdata", if_rdata1, r1_data);
        r1_due = -1;
      end else if (r1_due >= 0 && cyc > r1_due) begin
        fail_now("lat1_missing_rvalid");
        r1_due = -1;
      end
      acc_if1 = if_ready1;
      if (if_ready1) begin
        if (g1_last >= 0) chk("lat1_grant_gap", 32'(cyc - g1_last), 32'd3);
        chk("lat1_mem_addr", mem_addr1, if_addr1);
        g1_last = cyc;
        g1_cnt++;
        r1_cyc  = cyc + 1;
        r1_due  = cyc + 2;
        r1_data = if_addr1 ^ 32'hC3C3_0000;
      end
    end
    mem_rdata1 = (cyc == r1_cyc) ? r1_data : $urandom();
  end

  // ---------------- driver helpers ----------------
  task automatic wait_acc(input bit ds, output int t);
    t = -1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (ds ? acc_ds : acc_if) begin
        t = cyc - 1;
        break;
      end
    end
    if (ds) ds_req = 1'b0; else if_req = 1'b0;
    if (t < 0) fail_now("accept_timeout");
  endtask

  task automatic do_req(input bit ds, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int t);
    if (ds) begin
      ds_req = 1'b1; ds_we = we; ds_addr = addr; ds_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    wait_acc(ds, t);
  endtask

  task automatic wait_rv(input bit ds, input int t, input int lat, input string nm);
    int seen = -1;
    for (int i = 0; i < 20 && seen < 0; i++) begin
      @(negedge clk);
      if (ds ? ds_rvalid : if_rvalid) seen = cyc;
    end
    chk(nm, 32'(seen - t), 32'(lat));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t, t2, g0;
    bit pat [8];
    pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_rdata", if_rdata, 32'h0);

    // lone load
    mem_model[32'h40] = 32'h1234_5678;
    do_req(1'b1, 1'b0, 32'h40, 32'h0, t);
    wait_rv(1'b1, t, 3, "lone_load_latency");
    chk("lone_load_data", ds_rdata, 32'h1234_5678);
    chk("lone_load_if_rvalid", 32'(if_rvalid), 32'd0);
    @(posedge clk); #1;

    // store, then a fetch waiting behind it, then read the store back
    do_req(1'b1, 1'b1, 32'h80, 32'hDEAD_BEEF, t);
    do_req(1'b0, 1'b0, 32'h84, 32'h0, t2);
    chk("store_next_grant", 32'(t2 - t), 32'd4);
    do_req(1'b1, 1'b0, 32'h80, 32'h0, t);
    wait_rv(1'b1, t, 3, "readback_latency");
    chk("store_readback", ds_rdata, 32'hDEAD_BEEF);
    repeat (2) @(posedge clk); #1;

    // continuous contention: starvation pattern
    g0 = glog.size();
    if_req = 1'b1; if_addr = 32'h300;
    ds_req = 1'b1; ds_we = 1'b0; ds_addr = 32'h10;
    for (int i = 0; i < 100 && glog.size() < g0 + 8; i++) begin
      @(posedge clk); #1;
    end
    if_req = 1'b0; ds_req = 1'b0;
    for (int i = 0; i < 8; i++)
      chk($sformatf("grant_seq_%0d", i),
          (glog.size() > g0 + i) ? 32'(glog[g0 + i]) : 32'd2, 32'(pat[i]));
    repeat (5) @(posedge clk); #1;

    // reset in the middle of a fetch
    do_req(1'b0, 1'b0, 32'h100, 32'h0, t);
    ds_req = 1'b1; ds_we = 1'b0; ds_addr = 32'h44;
    reset = 1'b1;
    #1 chk("reset_immediate", outs_or(), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_acc(1'b1, t);
    wait_rv(1'b1, t, 3, "post_reset_latency");
    chk("post_reset_data", ds_rdata, rd(32'h44));
    repeat (3) @(posedge clk); #1;

    // latency-1 back-to-back fetches
    lat1_on = 1'b1;
    if_req1 = 1'b1; if_addr1 = 32'h200;
    for (int i = 0; i < 60 && g1_cnt < 6; i++) begin
      @(posedge clk); #1;
      if (acc_if1) if_addr1 = if_addr1 + 32'd4;
    end
    if_req1 = 1'b0;
    chk("lat1_grant_count", 32'(g1_cnt), 32'd6);
    repeat (4) @(posedge clk); #1;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (if_req && (acc_if || $urandom_range(0, 19) == 0)) if_req = 1'b0;
      else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req  = 1'b1;
        if_addr = 32'($urandom_range(0, 31)) << 2;
      end
      if (ds_req && (acc_ds || $urandom_range(0, 19) == 0)) ds_req = 1'b0;
      else if (!ds_req && $urandom_range(0, 1) == 0) begin
        ds_req   = 1'b1;
        ds_we    = 1'($urandom_range(0, 1));
        ds_addr  = 32'($urandom_range(0, 31)) << 2;
        ds_wdata = $urandom();
      end
    end
    if_req = 1'b0; ds_req = 1'b0;
    repeat (10) @(posedge clk); #1;
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
